// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1-to-4 valid/ready demultiplexer with addressed or round-robin lane selection
module demux1to4_stream #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             rr_en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr
);
    logic [3:0][WIDTH-1:0] data_q, data_d;
    logic [3:0]            valid_q, valid_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            tgt;
    logic                  accept;

    always_comb begin
        tgt      = rr_en ? ptr_q : sel;
        in_ready = !valid_q[tgt] | out_ready[tgt];
        accept   = in_valid & in_ready;
        valid_d  = valid_q & ~out_ready;
        data_d   = data_q;
        if (accept) begin
            valid_d[tgt] = 1'b1;
            data_d[tgt]  = in_data;
        end
        ptr_d = (accept && rr_en) ? ptr_q + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out_valid = valid_q;
    assign rr_ptr    = ptr_q;
endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed self-checking bench for demux1to4_stream
module tb_demux1to4_stream;
    localparam int W = 48;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   sel = '0;
    logic         rr_en = 1'b0;
    logic [W-1:0] out0, out1, out2, out3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = '0;
    logic [1:0]   rr_ptr;
    logic [W-1:0] outs [4];
    int errors = 0;
    int checks = 0;

    demux1to4_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .rr_en(rr_en), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;

    // inputs change and outputs are sampled 1ns after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr_en = 1'b1;
        in_valid = 1'b1;
        in_data = W'(48'hDEAD);
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
        checks++;
        if (rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got=%0d exp=0", rr_ptr); end
        checks++;
        if ({out0, out1, out2, out3} !== '0) begin errors++; $display("FAIL reset_data got=%0h %0h %0h %0h exp=0", out0, out1, out2, out3); end
        step();
        rst = 1'b0;
        rr_en = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_addressed();
        logic [W-1:0] exp;
        rr_en = 1'b0;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = W'(48'h111 * (k + 1));
            sel = 2'(k);
            in_data = exp;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL addr_in_ready lane=%0d got=%b exp=1", k, in_ready); end
            step();
            checks++;
            if (outs[k] !== exp || out_valid[k] !== 1'b1) begin errors++; $display("FAIL addr_load lane=%0d got=%0h/%b exp=%0h/1", k, outs[k], out_valid[k], exp); end
        end
        checks++;
        if (out_valid !== 4'b1111 || rr_ptr !== 2'd0) begin errors++; $display("FAIL addr_end got=%b/%0d exp=1111/0", out_valid, rr_ptr); end
        sel = 2'd2;
        in_data = W'(48'h555);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL addr_full_ready got=%b exp=0", in_ready); end
        step();
        checks++;
        if (out2 !== W'(48'h333) || out_valid !== 4'b1111) begin errors++; $display("FAIL addr_full_hold got=%0h/%b exp=333/1111", out2, out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp;
        int lane;
        rr_en = 1'b1;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = W'(48'hA0 + k);
            lane = k % 4;
            in_data = exp;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready k=%0d got=%b exp=1", k, in_ready); end
            step();
            checks++;
            if (outs[lane] !== exp || out_valid !== 4'(1 << lane)) begin errors++; $display("FAIL rr_lane k=%0d got=%0h/%b exp=%0h/lane%0d", k, outs[lane], out_valid, exp, lane); end
            checks++;
            if (rr_ptr !== 2'((k + 1) % 4)) begin errors++; $display("FAIL rr_ptr k=%0d got=%0d exp=%0d", k, rr_ptr, (k + 1) % 4); end
        end
        checks++;
        if (out0 !== W'(48'hA4)) begin errors++; $display("FAIL rr_out0_wrap got=%0h exp=a4", out0); end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000 || rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_idle got=%b/%0d exp=0000/2", out_valid, rr_ptr); end
    endtask

    task automatic test_pass_through();
        rr_en = 1'b0;
        out_ready = 4'b0000;
        sel = 2'd1;
        in_valid = 1'b1;
        in_data = W'(48'h5);
        step();
        out_ready = 4'b0010;
        in_data = W'(48'h6);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_in_ready got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out1 !== W'(48'h6) || out_valid[1] !== 1'b1) begin errors++; $display("FAIL pass_load got=%0h/%b exp=6/1", out1, out_valid[1]); end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000 || out1 !== W'(48'h6)) begin errors++; $display("FAIL pass_drain got=%b/%0h exp=0000/6", out_valid, out1); end
        out_ready = 4'b0000;
    endtask

    task automatic test_stall();
        rr_en = 1'b0;
        sel = 2'd2;
        in_valid = 1'b1;
        in_data = W'(48'h77);
        step();
        rr_en = 1'b1;
        in_data = W'(48'h88);
        #1;
        checks++;
        if (in_ready !== 1'b0 || rr_ptr !== 2'd2) begin errors++; $display("FAIL stall_ready got=%b/%0d exp=0/2", in_ready, rr_ptr); end
        step();
        checks++;
        if (rr_ptr !== 2'd2 || out2 !== W'(48'h77) || out_valid !== 4'b0100) begin errors++; $display("FAIL stall_hold got=%0d/%0h/%b exp=2/77/0100", rr_ptr, out2, out_valid); end
        out_ready = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out2 !== W'(48'h88) || rr_ptr !== 2'd3 || out_valid !== 4'b0100) begin errors++; $display("FAIL stall_release got=%0h/%0d/%b exp=88/3/0100", out2, rr_ptr, out_valid); end
        in_valid = 1'b0;
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
    endtask

    task automatic test_mode_switch();
        logic [W-1:0] exp;
        rr_en = 1'b1;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        in_data = W'(48'hB0);
        step();
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (rr_ptr !== 2'd1 || out_valid !== 4'b0000) begin errors++; $display("FAIL mode_setup got=%0d/%b exp=1/0000", rr_ptr, out_valid); end
        rr_en = 1'b0;
        sel = 2'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = W'(48'hC0 + k);
            in_data = exp;
            step();
            checks++;
            if (out3 !== exp || rr_ptr !== 2'd1) begin errors++; $display("FAIL mode_sel k=%0d got=%0h/%0d exp=%0h/1", k, out3, rr_ptr, exp); end
        end
        rr_en = 1'b1;
        in_data = W'(48'hD0);
        step();
        checks++;
        if (out1 !== W'(48'hD0) || out_valid !== 4'b0010 || rr_ptr !== 2'd2) begin errors++; $display("FAIL mode_return got=%0h/%b/%0d exp=d0/0010/2", out1, out_valid, rr_ptr); end
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_addressed();
        test_round_robin();
        test_pass_through();
        test_stall();
        test_mode_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux1to4_stream.md
# demux1to4_stream

Registered 1-to-4 stream demultiplexer with valid/ready handshaking on every lane. It is the distribution-side counterpart of the slice's 4-to-1 operand select: one producer feeds four consumers, such as per-port operand staging for the pre-adder, multiplier and post-adder paths. The target lane is either addressed explicitly by `sel` or chosen by an internal round-robin pointer. Each lane holds one word until its consumer accepts it.

## Interface
- `WIDTH`, default 48: data width of the input and of each output lane.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `in_data` input WIDTH: input word.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: the block accepts `in_data` this cycle. Combinational.
- `sel` input 2: explicit target lane, used when `rr_en`=0.
- `rr_en` input 1: 1 selects the round-robin target; 0 selects `sel`.
- `out0`, `out1`, `out2`, `out3` output WIDTH each: registered lane data.
- `out_valid` output 4: bit i means `out`i holds an unconsumed word.
- `out_ready` input 4: bit i means consumer i takes `out`i this cycle.
- `rr_ptr` output 2: current round-robin pointer. Registered.

## Operation
- Target lane: `tgt` = `rr_en` ? `rr_ptr` : `sel`. Combinational, evaluated every cycle.
- Ready: `in_ready` = !`out_valid[tgt]` | `out_ready[tgt]`.
  - Independent of `in_valid`.
  - Depends combinationally on `out_ready`, `sel`, `rr_en` and `rr_ptr`.
- Accept: a word is accepted when `in_valid` & `in_ready`.
- Accept effects on the next edge:
  - `out`tgt <= `in_data`.
  - `out_valid[tgt]` <= 1.
  - If `rr_en`=1, `rr_ptr` <= `rr_ptr`+1, wrapping 3 -> 0.
- Lane drain: for each lane i with `out_valid[i]` & `out_ready[i]` that is not loaded this cycle, `out_valid[i]` <= 0.
- Unloaded lane data: holds its value. Data is never cleared after reset; consumers must qualify it with `out_valid`.
- Simultaneous drain and load on the same lane: `out_valid` stays 1 and the lane takes the new word. No bubble.
- Drains on other lanes proceed in the same cycle, independently of the load.
- `rr_ptr` behaviour:
  - Advances only on an accept with `rr_en`=1.
  - Holds when there is no accept, or when `rr_en`=0.
  - Accepts made in `sel` mode do not move it.
- Switching `rr_en` or `sel` mid-stream: takes effect the same cycle through `tgt`. No state is flushed.
- Stability: while `out_valid[i]`=1 and `out_ready[i]`=0, `out`i is stable.
- Blocked target lane: if the target lane is full and its consumer is not ready, `in_ready`=0. The input stalls even when other lanes are empty; there is no lane skipping.
- Reset (`rst`=1, asynchronous):
  - `out0`..`out3` = 0.
  - `out_valid` = 4'b0000.
  - `rr_ptr` = 0.
  - `in_ready` then reads 1.
- Reset asserted mid-operation: all held words are discarded immediately. No handshake completes in a cycle where `rst`=1.

## Timing
- Latency: the word accepted at edge n appears on `out`tgt with `out_valid` high after edge n.
- Throughput: one word per cycle aggregate when the targeted consumer is ready or its lane is empty.
- Per-lane throughput: one word per cycle with `out_ready` held high.
- Round-robin rate: one lane per accepted word, in order 0,1,2,3,0,...
- Combinational paths: `out_ready` -> `in_ready` and `sel`/`rr_en` -> `in_ready` are single-level. No path exists from `in_valid` to `in_ready`.
- Registered outputs: all lane outputs and `rr_ptr` are register outputs.

## Test plan
- Reset state: assert `rst` asynchronously mid-cycle.
  - Immediately: `out_valid`=0000, `rr_ptr`=0, `out0`..`out3`=0.
  - After release: `in_ready`=1.
- Addressed mode: `rr_en`=0, all `out_ready`=0; send 0x111, 0x222, 0x333, 0x444 with `sel`=0,1,2,3.
  - Each lane loads one cycle after accept.
  - End state: `out_valid`=1111, `rr_ptr`=0.
  - A fifth word with `sel`=2: `in_ready`=0 and nothing changes.
- Round-robin wrap: `rr_en`=1, `out_ready`=1111; stream 6 words 0xA0..0xA5.
  - Lanes receive 0,1,2,3,0,1.
  - `rr_ptr` sequence: 1,2,3,0,1,2.
  - `out0` shows 0xA0 then 0xA4.
- Full-lane pass-through: lane 1 holds 0x5; assert `out_ready[1]`=1 and send 0x6 with `sel`=1 in the same cycle.
  - `in_ready`=1.
  - Next cycle: `out1`=0x6 and `out_valid[1]` stays 1.
- Stall and no skip: `rr_en`=1, `rr_ptr`=2, lane 2 full, `out_ready[2]`=0, other lanes empty.
  - `in_ready`=0 and `rr_ptr` holds at 2.
  - Raise `out_ready[2]`: the word lands in lane 2 and `rr_ptr` becomes 3.
- Mode switch: `rr_ptr`=1; accept 3 words with `rr_en`=0, `sel`=3, then return to `rr_en`=1.
  - `rr_ptr` is still 1.
  - The next word goes to lane 1.
